// File: rtl/regfile_writeback_unit_pkg.sv
// Shared register-file constants used by the write-side front end and the register file itself.
package regfile_writeback_unit_pkg;
   localparam int         RF_DATA_WIDTH = 32;
   localparam int         RF_ADDR_WIDTH = 5;
   localparam int         REG_COUNT     = 32;
   localparam logic [4:0] ZERO_REG      = 5'd0;
endpackage

// File: rtl/regfile_writeback_fifo.sv
// Small power-of-two FIFO that buffers memory-path results until they win the write port.
module writeback_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push, do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/regfile_writeback_unit.sv
// Register-file write front end: ALU/memory arbitration, output register stage,
// pending-destination scoreboard and same-cycle read bypass.
module regfile_writeback_unit
   import regfile_writeback_unit_pkg::*;
#(
   parameter int DATA_WIDTH     = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = RF_ADDR_WIDTH,
   parameter int MEM_FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [ADDR_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic [ADDR_WIDTH-1:0] query_rs0,
   input  logic [ADDR_WIDTH-1:0] query_rs1,
   output logic                  busy_rs0,
   output logic                  busy_rs1,
   output logic                  byp_hit0,
   output logic                  byp_hit1,
   output logic [DATA_WIDTH-1:0] byp_data0,
   output logic [DATA_WIDTH-1:0] byp_data1,
   output logic                  rf_write_enable,
   output logic [ADDR_WIDTH-1:0] rf_write_address,
   output logic [DATA_WIDTH-1:0] rf_data_to_write
);
   localparam int NREG = 1 << ADDR_WIDTH;
   localparam int NPORT = 2;
   localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0] data;
   } wb_entry_t;

   wb_entry_t alu_ent, mem_ent, head, commit;
   logic      fifo_full, fifo_empty, push, pop, alu_take, commit_valid;
   logic      rf_from_mem;
   logic [NREG-1:0] sb, sb_next;
   logic      sb_clr_en, issue_conflict;

   assign alu_ent   = '{rd: alu_rd, data: alu_data};
   assign mem_ent   = '{rd: mem_rd, data: mem_data};
   assign alu_ready = !fifo_full;
   assign mem_ready = !fifo_full;
   assign push      = mem_valid && mem_ready;
   assign alu_take  = alu_valid && alu_ready;

   // A full FIFO always drains first; otherwise the ALU wins and the FIFO fills idle slots.
   assign pop          = !fifo_empty && (fifo_full || !alu_take);
   assign commit_valid = alu_take || !fifo_empty;
   assign commit       = pop ? head : alu_ent;

   writeback_fifo #(
      .WIDTH(ADDR_WIDTH + DATA_WIDTH),
      .DEPTH(MEM_FIFO_DEPTH)
   ) u_mem_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (mem_ent),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         rf_write_enable  <= 1'b0;
         rf_write_address <= '0;
         rf_data_to_write <= '0;
         rf_from_mem      <= 1'b0;
      end else begin
         rf_write_enable <= commit_valid && (commit.rd != ZERO);
         rf_from_mem     <= pop;
         if (commit_valid) begin
            rf_write_address <= commit.rd;
            rf_data_to_write <= commit.data;
         end
      end
   end

   // Clear lands on the same edge the register file captures; a same-edge issue wins.
   assign sb_clr_en = rf_write_enable && rf_from_mem;

   always_comb begin
      sb_next = sb;
      if (sb_clr_en) sb_next[rf_write_address] = 1'b0;
      if (issue_valid) sb_next[issue_rd] = 1'b1;
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) sb <= '0;
      else      sb <= sb_next;
   end

   assign issue_conflict = issue_valid && sb[issue_rd] &&
                           !(sb_clr_en && rf_write_address == issue_rd);

   issue_to_busy_rd: assert property (@(posedge clk) disable iff (!rst) !issue_conflict);

   logic [NPORT-1:0][ADDR_WIDTH-1:0] query;
   logic [NPORT-1:0]                 busy, hit;

   assign query = {query_rs1, query_rs0};

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      assign busy[p] = sb[query[p]];
      assign hit[p]  = rf_write_enable && (rf_write_address == query[p]) && (query[p] != ZERO);
   end

   assign busy_rs0  = busy[0];
   assign busy_rs1  = busy[1];
   assign byp_hit0  = hit[0];
   assign byp_hit1  = hit[1];
   assign byp_data0 = rf_data_to_write;
   assign byp_data1 = rf_data_to_write;
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed bench: expected commits queued at drive time, popped by a write-port monitor.
module tb_regfile_writeback_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, mem_valid, issue_valid;
   logic        alu_ready, mem_ready;
   logic [4:0]  alu_rd, mem_rd, issue_rd, query_rs0, query_rs1;
   logic [31:0] alu_data, mem_data;
   logic        busy_rs0, busy_rs1, byp_hit0, byp_hit1;
   logic [31:0] byp_data0, byp_data1;
   logic        rf_write_enable;
   logic [4:0]  rf_write_address;
   logic [31:0] rf_data_to_write;

   int checks = 0;
   int errors = 0;
   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   regfile_writeback_unit dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .query_rs0(query_rs0), .query_rs1(query_rs1),
      .busy_rs0(busy_rs0), .busy_rs1(busy_rs1),
      .byp_hit0(byp_hit0), .byp_hit1(byp_hit1),
      .byp_data0(byp_data0), .byp_data1(byp_data1),
      .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
      .rf_data_to_write(rf_data_to_write)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every register-file write must match the oldest outstanding expected commit.
   always @(negedge clk) begin
      if (rf_write_enable === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write observed=%0h expected=none",
                   {rf_write_address, rf_data_to_write});
         end
         if (exp_q.size() != 0) begin
            logic [36:0] e;
            e = exp_q.pop_front();
            checks++;
            assert ({rf_write_address, rf_data_to_write} === e) else begin
               errors++;
               $error("FAIL commit_order observed=%0h expected=%0h",
                      {rf_write_address, rf_data_to_write}, e);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      alu_valid = 0; mem_valid = 0; issue_valid = 0;
      alu_rd = 0; mem_rd = 0; issue_rd = 0; query_rs0 = 0; query_rs1 = 0;
      alu_data = 0; mem_data = 0;
      tick(); tick();
      chk("reset_we", rf_write_enable, 0);
      chk("reset_addr", rf_write_address, 0);
      chk("reset_data", rf_data_to_write, 0);
      chk("reset_mem_ready", mem_ready, 1);
      chk("reset_alu_ready", alu_ready, 1);
      rst = 1'b1;

      // 1: ALU only, bypass on both read ports
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; query_rs0 = 5; query_rs1 = 5;
      exp_q.push_back({5'd5, 32'hDEADBEEF});
      #1;
      chk("t1_alu_ready", alu_ready, 1);
      chk("t1_no_early_hit", byp_hit0, 0);
      tick();
      alu_valid = 0;
      #1;
      chk("t1_we", rf_write_enable, 1);
      chk("t1_addr", rf_write_address, 5);
      chk("t1_data", rf_data_to_write, 32'hDEADBEEF);
      chk("t1_hit0", byp_hit0, 1);
      chk("t1_hit1", byp_hit1, 1);
      chk("t1_byp0", byp_data0, 32'hDEADBEEF);
      chk("t1_busy0", busy_rs0, 0);
      tick();
      chk("t1_we_drop", rf_write_enable, 0);
      chk("t1_hit_drop", byp_hit0, 0);

      // 2: write to x0 is consumed silently
      alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; query_rs0 = 0;
      #1;
      chk("t2_alu_ready", alu_ready, 1);
      tick();
      alu_valid = 0;
      #1;
      chk("t2_we", rf_write_enable, 0);
      chk("t2_hit0", byp_hit0, 0);
      tick();

      // 3: ALU and memory together, FIFO empty
      alu_valid = 1; alu_rd = 1; alu_data = 32'hA1;
      mem_valid = 1; mem_rd = 2; mem_data = 32'hB2;
      exp_q.push_back({5'd1, 32'hA1});
      exp_q.push_back({5'd2, 32'hB2});
      #1;
      chk("t3_alu_ready", alu_ready, 1);
      chk("t3_mem_ready", mem_ready, 1);
      tick();
      alu_valid = 0; mem_valid = 0;
      chk("t3_c1_addr", rf_write_address, 1);
      chk("t3_c1_we", rf_write_enable, 1);
      tick();
      chk("t3_c2_addr", rf_write_address, 2);
      chk("t3_c2_data", rf_data_to_write, 32'hB2);
      chk("t3_c2_we", rf_write_enable, 1);
      tick();
      chk("t3_idle_we", rf_write_enable, 0);

      // 4: back-pressure with two buffered memory results
      alu_valid = 1; alu_rd = 3; alu_data = 32'hC3;
      mem_valid = 1; mem_rd = 4; mem_data = 32'hD4;
      exp_q.push_back({5'd3, 32'hC3});
      tick();
      alu_rd = 8; alu_data = 32'hC8;
      mem_rd = 9; mem_data = 32'hD9;
      exp_q.push_back({5'd8, 32'hC8});
      tick();
      alu_rd = 10; alu_data = 32'hCA; mem_valid = 0;
      exp_q.push_back({5'd4, 32'hD4});
      exp_q.push_back({5'd10, 32'hCA});
      exp_q.push_back({5'd9, 32'hD9});
      #1;
      chk("t4_full_mem_ready", mem_ready, 0);
      chk("t4_full_alu_ready", alu_ready, 0);
      chk("t4_addr_b", rf_write_address, 8);
      tick();
      chk("t4_head_addr", rf_write_address, 4);
      chk("t4_alu_resume", alu_ready, 1);
      tick();
      alu_valid = 0;
      chk("t4_alu_addr", rf_write_address, 10);
      tick();
      chk("t4_tail_addr", rf_write_address, 9);
      tick();
      chk("t4_idle_we", rf_write_enable, 0);

      // 5: scoreboard set/clear, then re-issue on the clearing edge
      issue_valid = 1; issue_rd = 7; query_rs0 = 7; query_rs1 = 7;
      tick();
      issue_valid = 0;
      chk("t5_busy0", busy_rs0, 1);
      chk("t5_busy1", busy_rs1, 1);
      mem_valid = 1; mem_rd = 7; mem_data = 32'h77;
      exp_q.push_back({5'd7, 32'h77});
      tick();
      mem_valid = 0;
      chk("t5_still_busy", busy_rs0, 1);
      tick();
      chk("t5_commit_we", rf_write_enable, 1);
      chk("t5_commit_addr", rf_write_address, 7);
      chk("t5_busy_at_commit", busy_rs0, 1);
      chk("t5_hit0", byp_hit0, 1);
      tick();
      chk("t5_busy_cleared", busy_rs0, 0);
      issue_valid = 1; issue_rd = 7;
      tick();
      issue_valid = 0;
      mem_valid = 1; mem_rd = 7; mem_data = 32'h78;
      exp_q.push_back({5'd7, 32'h78});
      tick();
      mem_valid = 0;
      tick();
      chk("t5_commit2_addr", rf_write_address, 7);
      issue_valid = 1; issue_rd = 7;
      tick();
      issue_valid = 0;
      chk("t5_reissue_busy", busy_rs0, 1);
      issue_valid = 1; issue_rd = 0; query_rs0 = 0;
      tick();
      issue_valid = 0;
      #1;
      chk("t5_x0_never_busy", busy_rs0, 0);

      // 6: reset with a full FIFO and a commit in the output stage
      alu_valid = 1; alu_rd = 12; alu_data = 32'hCC;
      mem_valid = 1; mem_rd = 13; mem_data = 32'hDD;
      issue_valid = 1; issue_rd = 16; query_rs0 = 16;
      exp_q.push_back({5'd12, 32'hCC});
      tick();
      issue_valid = 0;
      alu_rd = 14; alu_data = 32'hCE;
      mem_rd = 15; mem_data = 32'hDF;
      exp_q.push_back({5'd14, 32'hCE});
      tick();
      alu_valid = 0; mem_valid = 0;
      rst = 1'b0;
      #1;
      chk("t6_pre_full", mem_ready, 0);
      chk("t6_pre_busy", busy_rs0, 1);
      tick();
      chk("t6_we", rf_write_enable, 0);
      chk("t6_addr", rf_write_address, 0);
      chk("t6_data", rf_data_to_write, 0);
      chk("t6_mem_ready", mem_ready, 1);
      chk("t6_alu_ready", alu_ready, 1);
      chk("t6_busy0", busy_rs0, 0);
      chk("t6_busy1", busy_rs1, 0);
      rst = 1'b1;
      tick(); tick();
      chk("t6_dropped_we", rf_write_enable, 0);
      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
